// File: rtl/spi_host_wrap.sv
// Memory-mapped SPI master on ids_bus. Mode 0, MSB first, 8/16/32-bit transfers.
// Software loads TXDATA, sets start in CTRL, polls STATUS and then reads RXDATA.
`timescale 1ns/1ps
module spi_host_wrap #(
  parameter logic [31:0] SPI_CTRL    = 32'h8000_0010,
  parameter logic [31:0] SPI_STAT    = 32'h8000_0014,
  parameter logic [31:0] SPI_TX      = 32'h8000_0018,
  parameter logic [31:0] SPI_RX      = 32'h8000_001C,
  parameter logic [31:0] SPI_DIV     = 32'h8000_0020,
  parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_spih_addr,
  input  logic        i_spih_write,
  input  logic        i_spih_read,
  input  logic [3:0]  i_spih_size,
  input  logic [31:0] i_spih_din,
  output logic [31:0] o_spih_dout,
  output logic        o_sclk,
  output logic        o_cs,
  output logic        o_mosi,
  input  logic        i_miso
);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [5:0]  bits_reg, bits_next;
  logic [31:0] tx_shift_reg, tx_shift_next;
  logic [31:0] rx_shift_reg, rx_shift_next;
  logic [31:0] tx_data_reg, tx_data_next;
  logic [31:0] rx_data_reg, rx_data_next;
  logic [15:0] div_reg, div_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        hold_cs_reg, hold_cs_next;
  logic [1:0]  len_reg, len_next;
  logic        sclk_reg, sclk_next;
  logic        cs_reg, cs_next;
  logic        mosi_reg, mosi_next;
  logic [31:0] dout_reg, dout_next;
  logic [1:0]  miso_sync_reg;

  logic        busy;
  logic        wr_en;
  logic [5:0]  start_bits;
  logic [31:0] tx_aligned;

  assign busy  = (state_reg != IDLE);
  assign wr_en = i_spih_write && (i_spih_size != 4'd0);

  // Bit count and left-aligned shift image for a start issued with this CTRL word
  always_comb begin
    start_bits = 6'd32;
    tx_aligned = tx_data_reg;
    case (i_spih_din[2:1])
      2'd0: begin
        start_bits = 6'd8;
        tx_aligned = {tx_data_reg[7:0], 24'd0};
      end
      2'd1: begin
        start_bits = 6'd16;
        tx_aligned = {tx_data_reg[15:0], 16'd0};
      end
      default: begin
        start_bits = 6'd32;
        tx_aligned = tx_data_reg;
      end
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bits_next     = bits_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    tx_data_next  = tx_data_reg;
    rx_data_next  = rx_data_reg;
    div_next      = div_reg;
    rx_valid_next = rx_valid_reg;
    hold_cs_next  = hold_cs_reg;
    len_next      = len_reg;
    sclk_next     = sclk_reg;
    cs_next       = cs_reg;
    mosi_next     = mosi_reg;
    dout_next     = dout_reg;

    if (wr_en && i_spih_addr == SPI_TX)
      tx_data_next = i_spih_din;
    if (wr_en && i_spih_addr == SPI_DIV && !busy)
      div_next = i_spih_din[15:0];
    // CTRL is ignored entirely while a transfer is running
    if (wr_en && i_spih_addr == SPI_CTRL && !busy) begin
      len_next     = i_spih_din[2:1];
      hold_cs_next = i_spih_din[3];
      if (i_spih_din[0]) begin
        state_next    = LEAD;
        cnt_next      = div_reg;
        bits_next     = start_bits;
        tx_shift_next = tx_aligned;
        rx_shift_next = 32'd0;
        cs_next       = 1'b0;
        mosi_next     = tx_aligned[31];
        sclk_next     = 1'b0;
      end else if (!i_spih_din[3]) begin
        cs_next = 1'b1;
      end
    end

    if (i_spih_read) begin
      case (i_spih_addr)
        SPI_CTRL: dout_next = {28'd0, hold_cs_reg, len_reg, 1'b0};
        SPI_STAT: dout_next = {30'd0, rx_valid_reg, busy};
        SPI_TX:   dout_next = tx_data_reg;
        SPI_RX: begin
          dout_next     = rx_data_reg;
          rx_valid_next = 1'b0;
        end
        SPI_DIV:  dout_next = {16'd0, div_reg};
        default:  dout_next = 32'd0;
      endcase
    end

    // Completion below overrides a same-cycle read clear of rx_valid
    case (state_reg)
      LEAD, LOW: begin
        if (cnt_reg == 16'd0) begin
          state_next = HIGH;
          cnt_next   = div_reg;
          sclk_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      HIGH: begin
        if (cnt_reg == 16'd0) begin
          rx_shift_next = {rx_shift_reg[30:0], miso_sync_reg[1]};
          bits_next     = bits_reg - 6'd1;
          cnt_next      = div_reg;
          sclk_next     = 1'b0;
          if (bits_reg == 6'd1) begin
            state_next = TRAIL;
          end else begin
            state_next    = LOW;
            tx_shift_next = {tx_shift_reg[30:0], 1'b0};
            mosi_next     = tx_shift_reg[30];
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      TRAIL: begin
        if (cnt_reg == 16'd0) begin
          state_next    = IDLE;
          rx_data_next  = rx_shift_reg;
          rx_valid_next = 1'b1;
          cs_next       = ~hold_cs_reg;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 16'd0;
      bits_reg      <= 6'd0;
      tx_shift_reg  <= 32'd0;
      rx_shift_reg  <= 32'd0;
      tx_data_reg   <= 32'd0;
      rx_data_reg   <= 32'd0;
      div_reg       <= DEFAULT_DIV;
      rx_valid_reg  <= 1'b0;
      hold_cs_reg   <= 1'b0;
      len_reg       <= 2'd0;
      sclk_reg      <= 1'b0;
      cs_reg        <= 1'b1;
      mosi_reg      <= 1'b0;
      dout_reg      <= 32'd0;
      miso_sync_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bits_reg      <= bits_next;
      tx_shift_reg  <= tx_shift_next;
      rx_shift_reg  <= rx_shift_next;
      tx_data_reg   <= tx_data_next;
      rx_data_reg   <= rx_data_next;
      div_reg       <= div_next;
      rx_valid_reg  <= rx_valid_next;
      hold_cs_reg   <= hold_cs_next;
      len_reg       <= len_next;
      sclk_reg      <= sclk_next;
      cs_reg        <= cs_next;
      mosi_reg      <= mosi_next;
      dout_reg      <= dout_next;
      miso_sync_reg <= {miso_sync_reg[0], i_miso};
    end
  end

  assign o_spih_dout = dout_reg;
  assign o_sclk      = sclk_reg;
  assign o_cs        = cs_reg;
  assign o_mosi      = mosi_reg;

endmodule

// File: tb/tb_spi_host_wrap.sv
// Self-checking bench for spi_host_wrap: table vectors, random transfers against
// a bit-level SPI slave model, plus hold_cs, busy-write and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_spi_host_wrap;

  localparam logic [31:0] SPI_CTRL = 32'h8000_0010;
  localparam logic [31:0] SPI_STAT = 32'h8000_0014;
  localparam logic [31:0] SPI_TX   = 32'h8000_0018;
  localparam logic [31:0] SPI_RX   = 32'h8000_001C;
  localparam logic [31:0] SPI_DIV  = 32'h8000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [3:0]  size = 4'hF;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        sclk, cs, mosi, miso;

  spi_host_wrap dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spih_addr(addr), .i_spih_write(wr),
    .i_spih_read(rd), .i_spih_size(size), .i_spih_din(din), .o_spih_dout(dout),
    .o_sclk(sclk), .o_cs(cs), .o_mosi(mosi), .i_miso(miso)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Pin monitors: edge counts, captured MOSI stream, high/low time
  int          rise_cnt = 0, fall_cnt = 0, high_total = 0, cs_low_total = 0, cs_rise_cnt = 0;
  logic [31:0] mosi_hist = 32'd0;
  always @(posedge sclk) begin
    rise_cnt  = rise_cnt + 1;
    mosi_hist = {mosi_hist[30:0], mosi};
  end
  always @(negedge sclk) fall_cnt = fall_cnt + 1;
  always @(posedge cs) cs_rise_cnt = cs_rise_cnt + 1;
  always @(negedge clk) begin
    if (sclk) high_total = high_total + 1;
    if (!cs) cs_low_total = cs_low_total + 1;
  end

  // SPI slave: presents bit idx of its word MSB first, advancing on each SCLK fall
  int          slave_len = 8;
  int          fall_base = 0;
  int          slave_idx;
  logic [31:0] slave_val = 32'd0;
  bit          loopback = 1'b0;
  always_comb begin
    slave_idx = fall_cnt - fall_base;
    if (loopback) miso = mosi;
    else if (slave_idx >= 0 && slave_idx < slave_len) miso = slave_val[slave_len - 1 - slave_idx];
    else miso = 1'b0;
  end

  typedef struct {
    logic [1:0]  len;
    logic [15:0] div;
    logic [31:0] tx;
    logic [31:0] sval;
    bit          lb;
    bit          hold;
    bit          chk;
    logic [31:0] exp_rx;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  function automatic int len_bits(input logic [1:0] len);
    return (len == 2'd0) ? 8 : (len == 2'd1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] low_mask(input int n);
    logic [31:0] one;
    one = 32'd1;
    return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'd1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Bus tasks are entered just after a falling clock edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = dout;
  endtask

  task automatic arm_slave(input vec_t v);
    slave_val = v.sval;
    slave_len = len_bits(v.len);
    loopback  = v.lb;
    fall_base = fall_cnt;
  endtask

  task automatic run_xfer(input vec_t v, input string nm);
    int L, D, rb, hb, busy_cnt;
    logic [31:0] st, r, m;
    L = len_bits(v.len);
    D = int'(v.div) + 1;
    m = low_mask(L);
    bus_write(SPI_DIV, {16'd0, v.div});
    bus_write(SPI_TX, v.tx);
    arm_slave(v);
    rb = rise_cnt;
    hb = high_total;
    bus_write(SPI_CTRL, {28'd0, v.hold, v.len, 1'b1});
    busy_cnt = 0;
    st = 32'd1;
    for (int c = 0; c < 20000 && st[0]; c++) begin
      bus_read(SPI_STAT, st);
      if (st[0]) busy_cnt = busy_cnt + 1;
    end
    check({nm, " done_status"}, st, 32'h2);
    check({nm, " busy_clocks"}, 32'(busy_cnt), 32'(v.exp_busy));
    check({nm, " sclk_rises"}, 32'(rise_cnt - rb), 32'(L));
    check({nm, " sclk_high_clocks"}, 32'(high_total - hb), 32'(L * D));
    check({nm, " mosi_bits"}, mosi_hist & m, v.tx & m);
    bus_read(SPI_RX, r);
    if (v.chk) check({nm, " rxdata"}, r, v.exp_rx);
    bus_read(SPI_STAT, st);
    check({nm, " status_after_rx_read"}, st, 32'h0);
    check({nm, " cs_after"}, {31'd0, cs}, {31'd0, ~v.hold});
    $display("xfer %s len=%0d div=%0d tx=%08h rx=%08h busy=%0d", nm, L, v.div, v.tx, r, busy_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, prev;
    vec_t v;
    int rb, hb, cb, crb, L;

    vecs[0] = '{len: 2'd0, div: 16'd2, tx: 32'h0000_00A5, sval: 32'd0, lb: 1'b1, hold: 1'b0, chk: 1'b1,
                exp_rx: 32'h0000_00A5, exp_busy: 51};
    vecs[1] = '{len: 2'd2, div: 16'd2, tx: 32'hDEAD_BEEF, sval: 32'h1234_5678, lb: 1'b0, hold: 1'b0, chk: 1'b1,
                exp_rx: 32'h1234_5678, exp_busy: 195};
    vecs[2] = '{len: 2'd1, div: 16'd3, tx: 32'h0000_1234, sval: 32'h0000_BEEF, lb: 1'b0, hold: 1'b0, chk: 1'b1,
                exp_rx: 32'h0000_BEEF, exp_busy: 132};
    vecs[3] = '{len: 2'd3, div: 16'd4, tx: 32'hCAFE_F00D, sval: 32'h8000_0001, lb: 1'b0, hold: 1'b0, chk: 1'b1,
                exp_rx: 32'h8000_0001, exp_busy: 325};
    vecs[4] = '{len: 2'd0, div: 16'd7, tx: 32'hFFFF_FF3C, sval: 32'h0000_0081, lb: 1'b0, hold: 1'b0, chk: 1'b1,
                exp_rx: 32'h0000_0081, exp_busy: 136};
    // Out-of-range divider: must still finish with correct timing, data unchecked
    vecs[5] = '{len: 2'd1, div: 16'd0, tx: 32'h0000_1234, sval: 32'h0000_FFFF, lb: 1'b0, hold: 1'b0, chk: 1'b0,
                exp_rx: 32'h0, exp_busy: 33};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_cs", {31'd0, cs}, 32'd1);
    check("reset_sclk", {31'd0, sclk}, 32'd0);
    check("reset_mosi", {31'd0, mosi}, 32'd0);
    check("reset_dout", dout, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(SPI_STAT, r); check("reset_status", r, 32'h0);
    bus_read(SPI_DIV, r);  check("reset_clkdiv", r, 32'd4);
    bus_read(SPI_RX, r);   check("reset_rxdata", r, 32'h0);
    bus_read(SPI_TX, r);   check("reset_txdata", r, 32'h0);
    bus_read(SPI_CTRL, r); check("reset_ctrl", r, 32'h0);

    // Unmapped access, dout hold, zero byte-enable write
    bus_write(32'h8000_0024, 32'h1234_5678);
    bus_read(SPI_DIV, prev);
    @(negedge clk);
    check("dout_holds", dout, prev);
    bus_read(32'h8000_0024, r); check("unmapped_read", r, 32'h0);
    bus_write(SPI_TX, 32'h0000_0011);
    size = 4'h0;
    bus_write(SPI_TX, 32'hFFFF_FFFF);
    size = 4'hF;
    bus_read(SPI_TX, r); check("size0_write_ignored", r, 32'h11);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Two held-CS words, then a clearing CTRL write
    crb = cs_rise_cnt;
    v = '{len: 2'd1, div: 16'd2, tx: 32'h0000_A5A5, sval: 32'h0000_0F0F, lb: 1'b0, hold: 1'b1, chk: 1'b1,
          exp_rx: 32'h0000_0F0F, exp_busy: 99};
    run_xfer(v, "hold_w0");
    v.tx = 32'h0000_5A5A; v.sval = 32'h0000_F0F0; v.exp_rx = 32'h0000_F0F0;
    run_xfer(v, "hold_w1");
    check("hold_no_cs_pulse", 32'(cs_rise_cnt - crb), 32'd0);
    bus_read(SPI_CTRL, r); check("ctrl_readback", r, 32'h0000_000A);
    addr = SPI_CTRL; din = 32'h0; wr = 1'b1;
    #1;
    check("cs_low_before_clear", {31'd0, cs}, 32'd0);
    @(negedge clk);
    wr = 1'b0;
    check("cs_high_after_clear", {31'd0, cs}, 32'd1);
    check("cs_single_rise", 32'(cs_rise_cnt - crb), 32'd1);

    // Writes during a busy transfer
    v = '{len: 2'd0, div: 16'd2, tx: 32'h0000_00A5, sval: 32'd0, lb: 1'b1, hold: 1'b0, chk: 1'b1,
          exp_rx: 32'h0000_00A5, exp_busy: 51};
    bus_write(SPI_DIV, 32'd2);
    bus_write(SPI_TX, 32'h0000_00A5);
    arm_slave(v);
    rb = rise_cnt; hb = high_total; cb = cs_low_total;
    bus_write(SPI_CTRL, 32'h1);
    bus_write(SPI_CTRL, 32'h1);
    bus_write(SPI_DIV, 32'd9);
    bus_write(SPI_TX, 32'h55);
    r = 32'd1;
    for (int c = 0; c < 20000 && r[0]; c++) bus_read(SPI_STAT, r);
    check("busyw_done_status", r, 32'h2);
    check("busyw_cs_low_clocks", 32'(cs_low_total - cb), 32'd51);
    check("busyw_sclk_rises", 32'(rise_cnt - rb), 32'd8);
    check("busyw_high_clocks", 32'(high_total - hb), 32'd24);
    check("busyw_mosi_bits", mosi_hist & 32'hFF, 32'hA5);
    bus_read(SPI_RX, r);  check("busyw_rxdata", r, 32'hA5);
    bus_read(SPI_DIV, r); check("busyw_clkdiv_kept", r, 32'd2);
    bus_read(SPI_TX, r);  check("busyw_txdata_updated", r, 32'h55);
    $display("xfer busy_writes rx=000000a5");

    // Asynchronous reset after three SCLK rises
    v = '{len: 2'd2, div: 16'd2, tx: 32'hFFFF_0000, sval: 32'hAAAA_5555, lb: 1'b0, hold: 1'b0, chk: 1'b1,
          exp_rx: 32'h0, exp_busy: 0};
    bus_write(SPI_TX, v.tx);
    arm_slave(v);
    rb = rise_cnt;
    bus_write(SPI_CTRL, 32'h5);
    for (int c = 0; c < 2000 && (rise_cnt - rb) < 3; c++) @(negedge clk);
    check("rst_reached_3_rises", 32'(rise_cnt - rb), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_cs", {31'd0, cs}, 32'd1);
    check("rst_async_sclk", {31'd0, sclk}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(SPI_STAT, r); check("rst_status", r, 32'h0);
    bus_read(SPI_RX, r);   check("rst_rxdata", r, 32'h0);
    bus_read(SPI_DIV, r);  check("rst_clkdiv", r, 32'd4);
    $display("xfer reset_abort done");
    v = '{len: 2'd0, div: 16'd4, tx: 32'h0000_0096, sval: 32'h0000_0069, lb: 1'b0, hold: 1'b0, chk: 1'b1,
          exp_rx: 32'h0000_0069, exp_busy: 85};
    run_xfer(v, "post_reset");

    // Randomised transfers against the protocol model
    for (int i = 0; i < 8; i++) begin
      v.len  = 2'($urandom_range(0, 3));
      v.div  = 16'($urandom_range(2, 5));
      v.tx   = $urandom;
      v.sval = $urandom;
      v.lb   = 1'($urandom_range(0, 1));
      v.hold = 1'b0;
      v.chk  = 1'b1;
      L = len_bits(v.len);
      v.exp_rx   = (v.lb ? v.tx : v.sval) & low_mask(L);
      v.exp_busy = (2 * L + 1) * (int'(v.div) + 1);
      run_xfer(v, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_host_wrap.md
Name: spi_host_wrap

Overview:
- Memory-mapped SPI master peripheral. It is a slave on ids_bus, alongside the on-chip UART, and uses the same addr/write/read/size/din/dout port style.
- The core loads a word, starts a transfer, polls status and reads back the received word.
- It is the initiating end of the SPI link. It drives SCLK/CS/MOSI to an external SPI slave, e.g. a second ids chip's SPI slave port or a flash device.
- Fixed protocol: SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- SPI_CTRL, 32'h8000_0010, CTRL register address
- SPI_STAT, 32'h8000_0014, STATUS register address
- SPI_TX, 32'h8000_0018, TXDATA register address
- SPI_RX, 32'h8000_001C, RXDATA register address
- SPI_DIV, 32'h8000_0020, CLKDIV register address
- DEFAULT_DIV, 16'd4, CLKDIV reset value

Ports:
- i_clk  in  1  single system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_spih_addr  in  32  bus address, full-word compare against parameters
- i_spih_write  in  1  bus write strobe
- i_spih_read  in  1  bus read strobe
- i_spih_size  in  4  byte enables; any nonzero value writes the full 32-bit word
- i_spih_din  in  32  bus write data
- o_spih_dout  out  32  registered read data
- o_sclk  out  1  SPI clock
- o_cs  out  1  SPI chip select, active low
- o_mosi  out  1  SPI data out
- i_miso  in  1  SPI data in, asynchronous, 2-flop synchronised internally

Behaviour:
Reset:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: o_sclk=0, o_cs=1, o_mosi=0, o_spih_dout=0, TXDATA=0, RXDATA=0, CLKDIV=DEFAULT_DIV, busy=0, rx_valid=0, hold_cs=0, len=0, state=IDLE.
- Reset mid-transfer aborts immediately: CS deasserts, no rx_valid.

Registers:
- CTRL (write-only; reads return {28'b0, hold_cs, len, 1'b0}):
  - bit0 start: self-clearing pulse.
  - bits[2:1] len: 0=8 bits, 1=16, 2=32, 3=32.
  - bit3 hold_cs: keep CS low after the transfer for multi-word frames.
- STATUS (read-only): bit0 busy, bit1 rx_valid, others 0.
- TXDATA: read/write; right-aligned data to send. A write while busy updates the register and does not affect the current shift.
- RXDATA: read-only; right-aligned received bits, upper bits zero. A bus read clears rx_valid the same cycle the data is returned.
- CLKDIV: read/write, bits[15:0]. The half-period is CLKDIV+1 clocks. A write while busy is ignored.
- Unmapped addresses: reads return 0, writes are ignored.

Bus timing:
- Read data appears on o_spih_dout the cycle after i_spih_read, matching the SRAM latency. It holds until the next read.
- Writes take effect on the strobe edge.

FSM (states IDLE, LEAD, HIGH, LOW, TRAIL; each phase lasts D=CLKDIV+1 clocks, tracked by a 16-bit down-counter):
- IDLE:
  - A start write with busy=0 does the following on the same edge: latch len and hold_cs, load the shift register with TXDATA left-aligned to bit 31, set the bit count L to 8/16/32, set busy=1, o_cs=0, o_mosi=MSB, and go to LEAD.
  - A start while busy is ignored.
  - A start with hold_cs previously 1 keeps CS low throughout; no CS pulse occurs.
- LEAD: o_sclk=0 for D clocks, then go to HIGH.
- HIGH:
  - o_sclk=1 for D clocks.
  - On the last clock, shift the synchronised MISO into the receive shift register LSB.
  - Then go to LOW if bits remain, else go to TRAIL.
- LOW: on entry o_sclk=0 and o_mosi = next bit. Lasts D clocks, then go to HIGH.
- TRAIL:
  - o_sclk=0 for D clocks.
  - Then RXDATA = received L bits, rx_valid=1, busy=0, o_cs = ~hold_cs, go to IDLE.

Timing rules:
- Total transfer time from start to busy=0 is (2L+1)·D clocks.
- Exactly L rising SCLK edges per transfer.
- A new transfer overwrites RXDATA and sets rx_valid even if the previous value was unread.
- CLKDIV below 2 is out of spec: the MISO synchroniser latency then exceeds the high phase. The design must not lock up in that case; MISO data may be wrong.
- Clearing hold_cs: writing CTRL with hold_cs=0 and start=0 while idle drives o_cs=1 on the next edge.

Test Plan:
- Reset then read all registers: STATUS=0, CLKDIV=4, RXDATA=0; o_cs=1, o_sclk=0.
- CLKDIV=2, TXDATA=0xA5, CTRL=0x1, loop MOSI back to MISO:
  - MOSI bits 1,0,1,0,0,1,0,1 appear.
  - 8 SCLK rising edges, 3-clock half-period.
  - busy high for 51 clocks.
  - RXDATA=0x000000A5, STATUS=0x2, then 0x0 after RXDATA is read.
- len=32, TXDATA=0xDEADBEEF, MISO slave model returns 0x12345678 → RXDATA=0x12345678, 32 edges, busy for 65·D clocks.
- Two 16-bit transfers with hold_cs=1, then a CTRL write with hold_cs=0 → CS stays low across both words and rises one cycle after the clearing write.
- During a busy transfer, write a start, CLKDIV=9 and TXDATA=0x55:
  - Current transfer timing and data are unchanged.
  - CLKDIV still reads 2; TXDATA reads 0x55.
- Assert i_rst_n low mid-transfer (after 3 SCLK edges) → o_cs=1, o_sclk=0 asynchronously, STATUS=0. A subsequent transfer completes normally.
